// File: rtl/mux_scan_sequencer.sv
// Timed scanner for a 4:1 select mux: walks the enabled channels in index
// order, holds each select for DWELL cycles, and captures the mux output Z
// on the last cycle of each dwell.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | select parked at 00, waiting for start_i
// SCAN  | driving the select for ch_q, counting the dwell in cnt_q
module mux_scan_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] mask_i,
  input  logic       z_i,
  output logic       s0_o,
  output logic       s1_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       valid_o,
  output logic [3:0] samples_o
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      samples_q, samples_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;

  logic [1:0]      first_ch;
  logic [1:0]      nxt_ch;
  logic            nxt_found;

  // Lowest enabled channel of the incoming mask (where a new scan begins).
  always_comb begin
    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_i[i]) first_ch = 2'(i);
    end
  end

  // Next enabled channel above the current one in the latched mask.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = ch_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = 2'(i);
      end
    end
  end

  // Next-state and output logic; DONE defaults low so it only ever pulses.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    samples_d = samples_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          samples_d = 4'b0000;
          if (mask_i != 4'b0000) begin
            mask_d  = mask_i;
            valid_d = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            ch_d    = first_ch;
            state_d = ST_SCAN;
          end else begin
            // Nothing to scan: report an empty, completed result right away.
            done_d  = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (cnt_q == CNT_LAST) begin
          samples_d[ch_q] = z_i;
          if (nxt_found) begin
            ch_d  = nxt_ch;
            cnt_d = '0;
          end else begin
            done_d  = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            ch_d    = 2'd0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any scan without a DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ch_q      <= 2'd0;
      cnt_q     <= '0;
      mask_q    <= 4'b0000;
      samples_q <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      samples_q <= samples_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  assign s0_o      = ch_q[1];
  assign s1_o      = ch_q[0];
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign valid_o   = valid_q;
  assign samples_o = samples_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a behavioural 4:1 mux model feeds Z back,
// expected scan results are queued when a scan is launched and compared
// when the DUT pulses DONE.
module tb_mux_scan_sequencer;

  localparam int DWELL = 4;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       start_i;
  logic [3:0] mask_i;
  logic       z_i;
  logic       s0_o, s1_o, busy_o, done_o, valid_o;
  logic [3:0] samples_o;

  typedef struct {
    logic [3:0] samples;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc = 0;
  int         start_edge = 0;
  logic [3:0] zpat = 4'b0000;
  bit         glitch = 1'b0;
  int         rel_now;

  mux_scan_sequencer #(.DWELL(DWELL)) dut (
    .clk_i     (clk_sys),
    .rst_i     (rst),
    .start_i   (start_i),
    .mask_i    (mask_i),
    .z_i       (z_i),
    .s0_o      (s0_o),
    .s1_o      (s1_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .valid_o   (valid_o),
    .samples_o (samples_o)
  );

  always #5 clk_sys = ~clk_sys;

  // Edge counter used for all latency bookkeeping.
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Mux model; in glitch mode Z carries the wrong level except on the last
  // dwell cycle of each channel, so only a final-cycle capture is correct.
  always_comb begin
    rel_now = cyc - start_edge;
    if (glitch && rel_now >= 0 && (rel_now % DWELL) != DWELL - 1)
      z_i = ~zpat[{s0_o, s1_o}];
    else
      z_i = zpat[{s0_o, s1_o}];
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Launch a scan at the current negedge and follow it to DONE. With chain
  // set, returns in the DONE cycle so the caller can start again at once.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] zp, input bit glt,
                          input bit extra, input bit chain);
    logic [1:0] lst[4];
    int         n;
    int         rel;
    bit         got;
    exp_t       e;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        lst[n] = 2'(i);
        n++;
      end
    end
    zpat       = zp;
    glitch     = glt;
    mask_i     = m;
    start_i    = 1'b1;
    start_edge = cyc + 1;
    // DONE is registered on the accepting edge for an empty mask, otherwise
    // on the edge that ends the last dwell.
    exp_q.push_back('{samples: m & zp, lat: n * DWELL});
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_sys);
      rel     = cyc - start_edge;
      start_i = extra && (rel == 3 || rel == 9);
      mask_i  = 4'($urandom);
      if (done_o) begin
        e = exp_q.pop_front();
        check_val("samples", 32'(samples_o), 32'(e.samples));
        check_val("done_latency", 32'(rel), 32'(e.lat));
        check_val("valid_at_done", 32'(valid_o), 32'd1);
        check_val("busy_at_done", 32'(busy_o), 32'd0);
        check_val("sel_at_done", 32'({s0_o, s1_o}), 32'd0);
        got = 1'b1;
      end else if (n > 0 && rel < n * DWELL) begin
        check_val("busy_scan", 32'(busy_o), 32'd1);
        check_val("valid_scan", 32'(valid_o), 32'd0);
        check_val("sel_scan", 32'({s0_o, s1_o}), 32'(lst[rel / DWELL]));
      end
    end
    if (!got) begin
      check_val("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    start_i = 1'b0;
    glitch  = 1'b0;
    if (!chain) begin
      @(negedge clk_sys);
      check_val("done_one_cycle", 32'(done_o), 32'd0);
      check_val("valid_hold", 32'(valid_o), 32'd1);
      check_val("samples_hold", 32'(samples_o), 32'(m & zp));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, 32'({s0_o, s1_o, busy_o, done_o, valid_o, samples_o}), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    mask_i  = 4'b0000;
    #12;
    check_all_zero("reset_outputs");
    @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    check_all_zero("idle_after_reset");

    // Full scan, A..D = 1,0,0,1.
    run_scan(4'hF, 4'b1001, 1'b0, 1'b0, 1'b0);
    // Sparse mask, Z tied high.
    run_scan(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
    // Empty mask.
    run_scan(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    // Stray STARTs mid-scan, then a new scan launched in the DONE cycle.
    run_scan(4'hF, 4'b0110, 1'b0, 1'b1, 1'b1);
    run_scan(4'b0110, 4'b0101, 1'b0, 1'b0, 1'b0);
    // Z changes during each dwell; only the final-cycle level may land.
    run_scan(4'hF, 4'b0110, 1'b1, 1'b0, 1'b0);
    run_scan(4'b1001, 4'b1011, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a scan aborts it immediately.
    mask_i  = 4'hF;
    zpat    = 4'hF;
    start_i = 1'b1;
    @(negedge clk_sys);
    start_i = 1'b0;
    repeat (5) @(negedge clk_sys);
    check_val("busy_before_abort", 32'(busy_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset_midscan");
    repeat (20) begin
      @(negedge clk_sys);
      check_val("no_done_in_reset", 32'(done_o), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk_sys);
    run_scan(4'hF, 4'b1100, 1'b0, 1'b0, 1'b0);

    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
